ram_2p_be: RTL
==============

// Module: ram_2p_be
// PURPOSE
//   Synchronous true-dual-port SRAM model with per-byte write enables.
//   Read latency is 1 or 2 cycles and each port has its own valid pipeline.
//   Next-generation replacement for the single-port register-file RAM.
//   Serves instruction and data memories where a core port and a debug/loader port share one storage array.
// PARAMETERS
//   Width       32   data width in bits; must be a multiple of 8
//   Depth       128  number of words; need not be a power of two
//   ReadLatency 1    1 = rdata registered once; 2 = one extra output register stage
//   Aw          $clog2(Depth)  derived address width; do not override
// PORTS
//   clk_i      in   1        clock; all state updates on rising edge
//   rst_i      in   1        synchronous active-high reset
//   a_req_i    in   1        port A access request, one access per cycle
//   a_we_i     in   1        port A write (1) / read (0), sampled with a_req_i
//   a_be_i     in   Width/8  port A byte enables; bit k enables wdata[8k+7:8k]
//   a_addr_i   in   Aw       port A word address
//   a_wdata_i  in   Width    port A write data
//   a_rvalid_o out  1        port A response valid, ReadLatency cycles after request
//   a_rdata_o  out  Width    port A read data, qualified by a_rvalid_o
//   b_*        --   --       port B: identical set of signals (b_req_i ... b_rdata_o)
// BEHAVIOUR
//   Reset
//     - rst_i high at a clock edge clears a/b_rvalid_o and a/b_rdata_o to 0, including all pipeline stages.
//     - Storage contents are not reset.
//     - Requests sampled in the same cycle as rst_i are ignored: no write, no response.
//     - Reads in flight when reset asserts are dropped and never produce rvalid.
//   Access
//     - Every accepted request (req=1, rst=0) produces exactly one rvalid pulse, for writes as well as reads.
//     - Stage-1 response: rvalid and rdata update at edge N+1 for a request sampled at edge N.
//     - ReadLatency=2: the stage-1 response is re-registered once more, so it appears at edge N+2.
//     - Back-to-back requests give back-to-back rvalid pulses; throughput is 1 access per port per cycle.
//     - With no request, rdata holds its last value and rvalid deasserts.
//   Writes
//     - For each byte with be=1, storage[addr] takes that wdata byte; bytes with be=0 keep their value.
//     - be=0 with we=1 is a legal no-op write; it still returns rvalid.
//   Read data for a write
//     - Read-first: rdata returns the word as it was before the write in that cycle.
//   Port collisions (same address, same cycle)
//     - Read vs read: both ports return the same word.
//     - A writes, B reads: B gets the old word (read-first); the write still lands.
//     - Both write: per byte, port A wins wherever a_be[k]=1; port B's byte is written only where a_be[k]=0.
//   Out-of-range address (addr >= Depth)
//     - Writes are dropped.
//     - Reads return all-zero data.
//     - rvalid is still asserted.
//   Init
//     - If SRAM_INIT_FILE is defined, storage is loaded with $readmemh at time 0.
// TESTING
//   1. Hold rst_i for 2 cycles with a_req_i=1 -> rvalid/rdata stay 0; no storage write occurs.
//   2. A: write addr 5, be=4'b1111, data 32'hDEADBEEF; next cycle read addr 5 -> rdata 32'hDEADBEEF.
//      The read's rvalid arrives 1 cycle after request (ReadLatency=1) or 2 cycles after (ReadLatency=2).
//   3. Byte enables: addr 5 holds 32'hDEADBEEF; write be=4'b0101, data 32'h11223344; read -> 32'hDE22BE44.
//   4. Same cycle: A writes addr 9 <- 32'hA5A5A5A5 while B reads addr 9 (old value 0) -> B rdata 0.
//      A following B read of addr 9 -> 32'hA5A5A5A5.
//   5. Same cycle, both write addr 3: A be=4'b0011, data 32'h000000AA; B be=4'b1111, data 32'hBBBBBBBB.
//      Read addr 3 -> 32'hBBBB00AA.
//   6. Depth=100: read addr 120 -> rvalid=1, rdata=0; write addr 120 -> no other word changes.
//      Assert rst_i the cycle after a read with ReadLatency=2 -> that read never raises rvalid.

Source files
------------

// File: rtl/ram_2p_be.sv
// True-dual-port SRAM with per-byte write enables, read-first semantics and a
// 1- or 2-stage registered response path per port.
module ram_2p_be #(
    parameter int Width       = 32,
    parameter int Depth       = 128,
    parameter int ReadLatency = 1,
    parameter int Aw          = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               a_req_i,
    input  logic               a_we_i,
    input  logic [Width/8-1:0] a_be_i,
    input  logic [Aw-1:0]      a_addr_i,
    input  logic [Width-1:0]   a_wdata_i,
    output logic               a_rvalid_o,
    output logic [Width-1:0]   a_rdata_o,
    input  logic               b_req_i,
    input  logic               b_we_i,
    input  logic [Width/8-1:0] b_be_i,
    input  logic [Aw-1:0]      b_addr_i,
    input  logic [Width-1:0]   b_wdata_i,
    output logic               b_rvalid_o,
    output logic [Width-1:0]   b_rdata_o
);

    localparam int Nb = Width / 8;

    logic [Width-1:0] r_mem [Depth];

    logic             w_a_inr;
    logic             w_b_inr;
    logic [Width-1:0] w_a_rd;
    logic [Width-1:0] w_b_rd;

    logic             r_a_v1;
    logic             r_b_v1;
    logic [Width-1:0] r_a_d1;
    logic [Width-1:0] r_b_d1;

    // Out-of-range addresses never touch the array and read back as zero.
    assign w_a_inr = (32'(a_addr_i) < Depth);
    assign w_b_inr = (32'(b_addr_i) < Depth);
    assign w_a_rd  = w_a_inr ? r_mem[a_addr_i] : '0;
    assign w_b_rd  = w_b_inr ? r_mem[b_addr_i] : '0;

    // Storage update; port A is applied last so it wins per byte on a same-word clash.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < Nb; k++) begin
                if (b_req_i && b_we_i && w_b_inr && b_be_i[k]) begin
                    r_mem[b_addr_i][8*k +: 8] <= b_wdata_i[8*k +: 8];
                end
            end
            for (int k = 0; k < Nb; k++) begin
                if (a_req_i && a_we_i && w_a_inr && a_be_i[k]) begin
                    r_mem[a_addr_i][8*k +: 8] <= a_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // First response stage: captures the pre-write word for every accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
            r_a_d1 <= '0;
            r_b_d1 <= '0;
        end else begin
            r_a_v1 <= a_req_i;
            r_b_v1 <= b_req_i;
            if (a_req_i) begin
                r_a_d1 <= w_a_rd;
            end
            if (b_req_i) begin
                r_b_d1 <= w_b_rd;
            end
        end
    end

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic             r_a_v2;
            logic             r_b_v2;
            logic [Width-1:0] r_a_d2;
            logic [Width-1:0] r_b_d2;

            // Extra output stage; reset also drops whatever stage 1 was holding.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_a_v2 <= 1'b0;
                    r_b_v2 <= 1'b0;
                    r_a_d2 <= '0;
                    r_b_d2 <= '0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_b_v2 <= r_b_v1;
                    if (r_a_v1) begin
                        r_a_d2 <= r_a_d1;
                    end
                    if (r_b_v1) begin
                        r_b_d2 <= r_b_d1;
                    end
                end
            end

            assign a_rvalid_o = r_a_v2;
            assign a_rdata_o  = r_a_d2;
            assign b_rvalid_o = r_b_v2;
            assign b_rdata_o  = r_b_d2;
        end else begin : g_lat1
            assign a_rvalid_o = r_a_v1;
            assign a_rdata_o  = r_a_d1;
            assign b_rvalid_o = r_b_v1;
            assign b_rdata_o  = r_b_d1;
        end
    endgenerate

endmodule
